// File: rtl/cache_mem_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : diaosi_types_pkg
// Description : Shared types and default sizing for the cache/RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package diaosi_types_pkg;

    localparam int unsigned c_BURST_LEN  = 2;
    localparam int unsigned c_STARVE_MAX = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 32'd1 : $unsigned($clog2(n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter_if
// Description : icache, dcache and RAM bus signals seen by the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_mem_arbiter_if;

    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;

    // Arbiter side
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // Caches and RAM side
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface
`default_nettype wire

// File: rtl/cache_mem_arbiter_sat_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : arb_sat_counter
// Description : Saturating up-counter with clear priority and a saturation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_sat_counter #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned MAX   = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc_i,
    input  wire logic             clr_i,
    output logic [WIDTH-1:0]      cnt_o,
    output logic                  sat_o
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != c_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = (cnt_q == c_MAX);

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Shares one RAM port between icache and dcache; dcache first,
//               bursts held whole, icache forced in after STARVE_MAX bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter
    import diaosi_types_pkg::*;
#(
    parameter int unsigned BURST_LEN  = c_BURST_LEN,
    parameter int unsigned STARVE_MAX = c_STARVE_MAX
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    cache_mem_arbiter_if.slave bus
);

    localparam int unsigned c_BEAT_W   = cnt_width(BURST_LEN);
    localparam int unsigned c_STARVE_W = cnt_width(STARVE_MAX + 1);

    arb_state_t state_q;
    arb_state_t w_state;

    logic [c_BEAT_W-1:0]   beat_cnt_q;
    logic [c_STARVE_W-1:0] starve_cnt_q;
    logic                  w_beat_last;
    logic                  w_starved;

    logic w_d_req;
    logic w_i_beat;
    logic w_d_beat;
    logic w_d_done;
    logic w_d_drop;
    logic w_unused_cnt;

    assign w_d_req  = bus.dREN | bus.dWEN;
    assign w_i_beat = (state_q == GNT_I) && bus.ram_ready;
    assign w_d_beat = (state_q == GNT_D) && bus.ram_ready;
    assign w_d_done = w_d_beat && w_beat_last;
    assign w_d_drop = (state_q == GNT_D) && !bus.ram_ready && !w_d_req;

    arb_sat_counter #(
        .WIDTH (c_BEAT_W),
        .MAX   (BURST_LEN - 1)
    ) u_beat_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc_i (w_d_beat && !w_beat_last),
        .clr_i ((state_q != GNT_D) || w_d_done || w_d_drop),
        .cnt_o (beat_cnt_q),
        .sat_o (w_beat_last)
    );

    // Counts dcache bursts finished while the icache is kept waiting.
    arb_sat_counter #(
        .WIDTH (c_STARVE_W),
        .MAX   (STARVE_MAX)
    ) u_starve_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc_i (w_d_done && bus.iREN),
        .clr_i (w_i_beat || (w_d_done && !bus.iREN)),
        .cnt_o (starve_cnt_q),
        .sat_o (w_starved)
    );

    // Only the flags steer the FSM; raw counts stay visible for debug.
    assign w_unused_cnt = ^{beat_cnt_q, starve_cnt_q};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_d_req && !(bus.iREN && w_starved)) begin
                        state_q <= GNT_D;
                    end else if (bus.iREN) begin
                        state_q <= GNT_I;
                    end
                end
                GNT_I: begin
                    if (bus.ram_ready || !bus.iREN) begin
                        state_q <= IDLE;
                    end
                end
                GNT_D: begin
                    if (w_d_done || w_d_drop) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset overrides the registered state so an in-flight beat is dropped at once.
    assign w_state = RST ? IDLE : state_q;

    always_comb begin
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (w_state)
            GNT_I: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = !bus.ram_ready;
                bus.iload   = bus.ramload;
            end
            GNT_D: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dwait    = !bus.ram_ready;
                bus.dload    = bus.ramload;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
